// File: rtl/lif_pkg.sv
// Shared types and helpers for the LIF neuron layer: FSM state encoding,
// fixed-point unit constant and a signed saturation helper.
package lif_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UPDATE,
    ST_FINISH
  } state_e;

  localparam int FRAC_BITS = 8;
  localparam int ONE       = 1 << FRAC_BITS;

  // Clamp a wide signed value into the range of a w-bit signed word.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] s,
                                                  input int unsigned        w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (s > hi)      return hi;
    else if (s < lo) return lo;
    else             return s;
  endfunction

endpackage

// File: rtl/lif_neuron_array_core.sv
// Combinational leak/integrate/fire update for one neuron, shared by the
// whole layer in time.
module lif_update_core
  import lif_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int LEAK_SHIFT   = 4,
  parameter int REFRAC_STEPS = 4,
  parameter int RC_W         = 3
) (
  input  logic signed [DATA_WIDTH-1:0] v_i,
  input  logic        [RC_W-1:0]       rc_i,
  input  logic signed [DATA_WIDTH-1:0] in_current_i,
  input  logic signed [DATA_WIDTH-1:0] threshold_i,
  input  logic signed [DATA_WIDTH-1:0] v_reset_i,
  output logic signed [DATA_WIDTH-1:0] v_next_o,
  output logic        [RC_W-1:0]       rc_next_o,
  output logic                         fire_o
);

  // Two guard bits hold the worst case v - leak + current without wrap.
  logic signed [DATA_WIDTH+1:0] s;
  logic signed [DATA_WIDTH-1:0] v_sat;

  always_comb begin
    s         = (DATA_WIDTH+2)'(v_i) - (DATA_WIDTH+2)'(v_i >>> LEAK_SHIFT)
              + (DATA_WIDTH+2)'(in_current_i);
    v_sat     = DATA_WIDTH'(saturate(64'(s), DATA_WIDTH));
    v_next_o  = v_sat;
    rc_next_o = '0;
    fire_o    = 1'b0;
    if (rc_i != '0) begin
      rc_next_o = rc_i - RC_W'(1);
      v_next_o  = v_reset_i;
    end else if (v_sat >= threshold_i) begin
      fire_o    = 1'b1;
      v_next_o  = v_reset_i;
      rc_next_o = RC_W'(REFRAC_STEPS);
    end
  end

endmodule

// File: rtl/lif_neuron_array.sv
// Time-multiplexed layer of leaky integrate-and-fire neurons, one update per
// accepted input transfer. Optional per-timestep spike counter: LIF_SPIKE_COUNT_EN.
module lif_neuron_array
  import lif_pkg::*;
#(
  parameter int N_NEURONS    = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int LEAK_SHIFT   = 4,
  parameter int REFRAC_STEPS = 4,
  parameter int IDX_W        = $clog2(N_NEURONS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  step_start,
  input  logic [DATA_WIDTH-1:0] threshold,
  input  logic [DATA_WIDTH-1:0] v_reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_current,
  output logic [IDX_W-1:0]      cur_idx,
  output logic                  spike_valid,
  output logic [IDX_W-1:0]      spike_idx,
  output logic                  busy,
  output logic                  step_done
`ifdef LIF_SPIKE_COUNT_EN
  ,
  output logic [$clog2(N_NEURONS+1)-1:0] spike_count
`endif
);

  localparam int RC_W = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;

  state_e                               state_q, state_d;
  logic [IDX_W-1:0]                     idx_q, idx_d;
  logic [DATA_WIDTH-1:0]                thr_q, vrst_q;
  logic [N_NEURONS-1:0][DATA_WIDTH-1:0] v_q;
  logic [N_NEURONS-1:0][RC_W-1:0]       rc_q;
  logic                                 spk_vld_q;
  logic [IDX_W-1:0]                     spk_idx_q;

  logic                  xfer, start_acc, last;
  logic [DATA_WIDTH-1:0] v_next;
  logic [RC_W-1:0]       rc_next;
  logic                  fire;

  assign in_ready    = (state_q == ST_UPDATE);
  assign busy        = (state_q != ST_IDLE);
  assign step_done   = (state_q == ST_FINISH);
  assign cur_idx     = idx_q;
  assign spike_valid = spk_vld_q;
  assign spike_idx   = spk_idx_q;
  assign xfer        = in_ready & in_valid;
  assign start_acc   = (state_q == ST_IDLE) & step_start;
  assign last        = (idx_q == IDX_W'(N_NEURONS - 1));

  lif_update_core #(
    .DATA_WIDTH  (DATA_WIDTH),
    .LEAK_SHIFT  (LEAK_SHIFT),
    .REFRAC_STEPS(REFRAC_STEPS),
    .RC_W        (RC_W)
  ) u_core (
    .v_i         (v_q[idx_q]),
    .rc_i        (rc_q[idx_q]),
    .in_current_i(in_current),
    .threshold_i (thr_q),
    .v_reset_i   (vrst_q),
    .v_next_o    (v_next),
    .rc_next_o   (rc_next),
    .fire_o      (fire)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (step_start) begin
          state_d = ST_UPDATE;
          idx_d   = '0;
        end
      end
      ST_UPDATE: begin
        if (xfer) begin
          if (last) state_d = ST_FINISH;
          else      idx_d   = idx_q + IDX_W'(1);
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      thr_q  <= '0;
      vrst_q <= '0;
    end else if (start_acc) begin
      thr_q  <= threshold;
      vrst_q <= v_reset;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q  <= '0;
      rc_q <= '0;
    end else if (xfer) begin
      v_q[idx_q]  <= v_next;
      rc_q[idx_q] <= rc_next;
    end
  end

  // Spike is reported the cycle after its transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spk_vld_q <= 1'b0;
      spk_idx_q <= '0;
    end else begin
      spk_vld_q <= xfer & fire;
      if (xfer & fire) spk_idx_q <= idx_q;
    end
  end

`ifdef LIF_SPIKE_COUNT_EN
  logic [$clog2(N_NEURONS+1)-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)            cnt_q <= '0;
    else if (start_acc)   cnt_q <= '0;
    else if (xfer & fire) cnt_q <= cnt_q + 1'b1;
  end

  assign spike_count = cnt_q;
`endif

endmodule

// File: doc/lif_neuron_array.md
Name: lif_neuron_array

Overview:
Time-multiplexed layer of N leaky integrate-and-fire neurons sharing one update datapath. It is the parametrised successor to the single-neuron LIF block. Adds signed fixed-point state, runtime threshold and reset potential, a refractory period, valid/ready input flow control, and indexed spike output. It sits between the synaptic-current accumulator and the spike router. One "timestep" updates every neuron once, in index order.

Parameters:
N_NEURONS, 16, neurons in the layer (>=2)
DATA_WIDTH, 16, signed two's-complement width of current/membrane
FRAC_BITS, 8, fractional bits (1.0 = 1<<FRAC_BITS); documentation/test only, no RTL effect
LEAK_SHIFT, 4, leak = v >>> LEAK_SHIFT (arithmetic) per timestep
REFRAC_STEPS, 4, timesteps a neuron ignores input after firing
IDX_W, $clog2(N_NEURONS), neuron index width

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
step_start  in  1  one-cycle pulse; begins a timestep when idle
threshold  in  DATA_WIDTH  signed firing threshold; sampled on accepted step_start
v_reset  in  DATA_WIDTH  signed post-spike/refractory potential; sampled on accepted step_start
in_valid  in  1  in_current valid
in_ready  out  1  block accepts current for neuron at cur_idx
in_current  in  DATA_WIDTH  signed synaptic current for current neuron
cur_idx  out  IDX_W  neuron whose input is expected next
spike_valid  out  1  spike event this cycle
spike_idx  out  IDX_W  index of spiking neuron
busy  out  1  timestep in progress
step_done  out  1  one-cycle pulse; all neurons of this timestep updated

Behaviour:
- Reset: all outputs 0; every membrane register 0; every refractory counter 0; FSM to IDLE. Applies asynchronously, including mid-timestep.
- FSM states are IDLE, UPDATE, FINISH.
- IDLE: step_start latches threshold and v_reset, sets cur_idx=0, and moves to UPDATE. busy goes high the next cycle.
- UPDATE: in_ready=1. A transfer occurs when in_valid&in_ready.
  - With in_valid low, the FSM stalls: no neuron is skipped and no state changes.
  - After the transfer for N_NEURONS-1, the FSM moves to FINISH. Otherwise cur_idx increments.
- FINISH: one cycle. step_done=1, then return to IDLE. busy=0 in IDLE.
- step_start while busy is ignored.
- Per accepted transfer for neuron i:
  - Refractory (rc[i]>0): rc[i]--, v[i]=v_reset, input discarded, no spike.
  - Otherwise compute s = v - (v>>>LEAK_SHIFT) + in_current in DATA_WIDTH+2 bits. Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] to get v'.
  - If v' >= threshold (signed compare): spike, v[i]=v_reset, rc[i]=REFRAC_STEPS. Else v[i]=v'.
- Latency: spike_valid/spike_idx are registered and appear the cycle after the transfer. The spike for the last neuron is coincident with step_done.
- Back-to-back: with in_valid held high, a timestep takes N_NEURONS+2 cycles from step_start to step_done. A new step_start is accepted on the step_done cycle's successor (IDLE).
- REFRAC_STEPS=0 means no refractory period.

Optional Feature:
LIF_SPIKE_COUNT_EN
- Defined: adds output spike_count, width $clog2(N_NEURONS+1).
  - It counts spikes in the current timestep and clears on accepted step_start.
  - It holds its final value from step_done until the next step_start.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package lif_pkg holds:
  - FSM state typedef
  - saturate function (DATA_WIDTH+2 -> DATA_WIDTH)
  - fixed-point helper constant ONE = 1<<FRAC_BITS
- Sub-module lif_update_core (purely combinational) takes v, rc, in_current, threshold and v_reset. It returns v_next, rc_next and fire. The top holds the state arrays, FSM and output registers.

Test Plan:
All cases use defaults, so 1.0 = 0x0100.
- Integrate/fire: threshold=0x0400, v_reset=0, in_current=0x0100 to all neurons every step -> v sequence 256, 496, 721, 932, then spike on step 5 for all 16 neurons, with spike_idx 0..15 in order.
- Refractory: continue the above -> no spikes on steps 6-9, v held 0; next spike on step 14 (step 10 restarts integration, 256).
- Saturation:
  - Neuron 3 gets 0x7FFF each step with threshold=0x7FFF -> v saturates to 0x7FFF with no wrap, and it spikes.
  - Neuron 4 gets 0x8000 with threshold=0x7FFF -> v clamps at 0x8000 and never wraps positive.
- Backpressure: drop in_valid for 5 cycles at cur_idx=7 -> cur_idx stays 7, no spikes or state change. The step completes in N_NEURONS+2+5 cycles.
- Reset mid-step: assert reset while cur_idx=9 -> busy=0, all v=0, rc=0, FSM in IDLE. The next step behaves as step 1 of the first scenario.
- Ignored start plus feature: pulse step_start while busy -> no effect. With LIF_SPIKE_COUNT_EN, spike_count=16 at step 5 of the first scenario and 0 at step 6.
